// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_pkg
//  Description : Shared constants for the seven-segment display multiplexer:
//                active-low hex segment patterns ({a,b,c,d,e,f,g}, a = bit 6),
//                the all-off pattern and the BLANK/DRIVE FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

  localparam logic [6:0] SEG_0   = 7'h01;
  localparam logic [6:0] SEG_1   = 7'h4F;
  localparam logic [6:0] SEG_2   = 7'h12;
  localparam logic [6:0] SEG_3   = 7'h06;
  localparam logic [6:0] SEG_4   = 7'h4C;
  localparam logic [6:0] SEG_5   = 7'h24;
  localparam logic [6:0] SEG_6   = 7'h20;
  localparam logic [6:0] SEG_7   = 7'h0F;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h04;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h60;
  localparam logic [6:0] SEG_C   = 7'h31;
  localparam logic [6:0] SEG_D   = 7'h42;
  localparam logic [6:0] SEG_E   = 7'h30;
  localparam logic [6:0] SEG_F   = 7'h38;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_seg
//  Description : Combinational 4-bit hex to 7-segment decoder, active-low
//                cathodes ordered {a,b,c,d,e,f,g}.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  import seven_seg_pkg::*;

  // Map each hex value to its segment pattern.
  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seven_seg_mux.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_mux
//  Description : Time-multiplexed driver for a common-anode seven-segment
//                display. Each tick advances to the next digit after an
//                anti-ghosting blank interval. All display outputs registered.
//                Optional leading-zero blanking: define SEVEN_SEG_MUX_LZB_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_mux #(
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 100,
  parameter int IDX_W        = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [IDX_W-1:0]        digit_idx
);

  import seven_seg_pkg::*;

  // A zero-length blank would never leave BLANK cleanly, so it is stretched to one cycle.
  localparam int              BLANK_EFF = (BLANK_CYCLES < 1) ? 1 : BLANK_CYCLES;
  localparam int              CNT_W     = (BLANK_EFF > 1) ? $clog2(BLANK_EFF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLANK_EFF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        blank_cnt;
  logic [CNT_W-1:0]        blank_cnt_nxt;
  logic [IDX_W-1:0]        idx_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [6:0]              seg_nxt;
  logic                    dp_n_nxt;

  logic [3:0]              cur_nibble;
  logic                    cur_dp;
  logic [6:0]              cur_seg;
  logic [NUM_DIGITS-1:0]   drive_an;
  logic [NUM_DIGITS-1:0]   suppress;

`ifdef SEVEN_SEG_MUX_LZB_EN
  // Hide a zero digit when every enabled digit above it is also zero; digit 0 and dp digits always show.
  always_comb begin
    logic zeros_above;
    suppress    = '0;
    zeros_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if ((i != 0) && !dp[i] && (data[4*i +: 4] == 4'h0) && zeros_above) begin
        suppress[i] = 1'b1;
      end
      if (digit_en[i] && (data[4*i +: 4] != 4'h0)) begin
        zeros_above = 1'b0;
      end
    end
  end
`else
  assign suppress = '0;
`endif

  // Select the current digit's nibble and dp, and build its one-cold anode vector.
  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    drive_an   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        cur_nibble  = data[4*i +: 4];
        cur_dp      = dp[i];
        drive_an[i] = ~(digit_en[i] & ~suppress[i]);
      end
    end
  end

  hex_to_seg u_hex_to_seg (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // Next-state and next-output logic: outputs are blank unless a digit is being driven.
  always_comb begin
    state_nxt     = state;
    blank_cnt_nxt = blank_cnt;
    idx_nxt       = digit_idx;
    an_nxt        = '1;
    seg_nxt       = SEG_OFF;
    dp_n_nxt      = 1'b1;
    case (state)
      ST_BLANK: begin
        if (blank_cnt == CNT_LAST) begin
          state_nxt     = ST_DRIVE;
          blank_cnt_nxt = '0;
          an_nxt        = drive_an;
          seg_nxt       = cur_seg;
          dp_n_nxt      = ~cur_dp;
        end else begin
          blank_cnt_nxt = blank_cnt + CNT_W'(1);
        end
      end
      ST_DRIVE: begin
        if (tick) begin
          idx_nxt       = (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
          state_nxt     = ST_BLANK;
          blank_cnt_nxt = '0;
        end else begin
          an_nxt   = drive_an;
          seg_nxt  = cur_seg;
          dp_n_nxt = ~cur_dp;
        end
      end
      default: begin
        state_nxt     = ST_BLANK;
        blank_cnt_nxt = '0;
      end
    endcase
  end

  // State, counter, digit index and display output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_BLANK;
      blank_cnt <= '0;
      digit_idx <= '0;
      an        <= '1;
      seg       <= SEG_OFF;
      dp_n      <= 1'b1;
    end else begin
      state     <= state_nxt;
      blank_cnt <= blank_cnt_nxt;
      digit_idx <= idx_nxt;
      an        <= an_nxt;
      seg       <= seg_nxt;
      dp_n      <= dp_n_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_mux
//  Description : Self-checking bench for seven_seg_mux (8 digits, 4-cycle
//                blank) against a behavioural display model. Honours
//                SEVEN_SEG_MUX_LZB_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_mux;

  localparam int N     = 8;
  localparam int BLANK = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [31:0] data = 32'h0;
  logic [7:0]  dp = 8'h0;
  logic [7:0]  digit_en = 8'hFF;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic [2:0]  digit_idx;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] hex_tbl [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  // Model: which digit is selected, and how many blank cycles remain before it shows.
  int         m_idx;
  int         m_blank_left;
  logic [7:0] m_an;
  logic [6:0] m_seg;
  logic       m_dpn;

  seven_seg_mux #(
    .NUM_DIGITS   (N),
    .BLANK_CYCLES (BLANK),
    .IDX_W        (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .data      (data),
    .dp        (dp),
    .digit_en  (digit_en),
    .an        (an),
    .seg       (seg),
    .dp_n      (dp_n),
    .digit_idx (digit_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic lzb_hidden(input int i);
`ifdef SEVEN_SEG_MUX_LZB_EN
    if (i == 0 || dp[i]) return 1'b0;
    if (data[4*i +: 4] != 4'h0) return 1'b0;
    for (int j = i + 1; j < N; j++)
      if (digit_en[j] && data[4*j +: 4] != 4'h0) return 1'b0;
    return 1'b1;
`else
    return (i < 0);
`endif
  endfunction

  task automatic model_reset();
    m_idx        = 0;
    m_blank_left = BLANK;
    m_an         = 8'hFF;
    m_seg        = 7'h7F;
    m_dpn        = 1'b1;
  endtask

  task automatic model_blank();
    m_an  = 8'hFF;
    m_seg = 7'h7F;
    m_dpn = 1'b1;
  endtask

  task automatic model_show();
    m_an = 8'hFF;
    if (digit_en[m_idx] && !lzb_hidden(m_idx)) m_an[m_idx] = 1'b0;
    m_seg = hex_tbl[data[4*m_idx +: 4]];
    m_dpn = ~dp[m_idx];
  endtask

  // One clock edge of the display behaviour, from the inputs present at that edge.
  task automatic model_update();
    if (rst) begin
      model_reset();
    end else if (m_blank_left > 0) begin
      m_blank_left--;
      if (m_blank_left == 0) model_show();
      else model_blank();
    end else if (tick) begin
      m_idx        = (m_idx + 1) % N;
      m_blank_left = BLANK;
      model_blank();
    end else begin
      model_show();
    end
  endtask

  task automatic compare_all();
    check("an", {24'h0, an}, {24'h0, m_an});
    check("seg", {25'h0, seg}, {25'h0, m_seg});
    check("dp_n", {31'h0, dp_n}, {31'h0, m_dpn});
    check("digit_idx", {29'h0, digit_idx}, m_idx);
    check("one_anode", {31'h0, ($countones(~an) <= 1)}, 32'h1);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  // Pulse tick (assumes DRIVE) and count observed blank cycles; blank_is_dp selects dp_n as the blank indicator.
  task automatic tick_and_measure(input logic blank_is_dp, output int n);
    tick = 1'b1;
    step();
    tick = 1'b0;
    n = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (blank_is_dp ? (dp_n == 1'b1) : (an == 8'hFF)) n++;
      else break;
    end
  endtask

  task automatic advance();
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (BLANK) step();
  endtask

  initial begin
    int blen;
    logic [7:0] exp_an;
    model_reset();
    data     = 32'h76543210;
    digit_en = 8'hFF;
    dp       = 8'h00;
    repeat (2) step();
    check("reset_an", {24'h0, an}, 32'hFF);
    check("reset_seg", {25'h0, seg}, 32'h7F);
    @(negedge clk);
    rst = 1'b0;

    // First digit appears BLANK cycles after reset release.
    repeat (BLANK - 1) begin
      step();
      check("first_blank", {24'h0, an}, 32'hFF);
    end
    step();
    check("first_an", {24'h0, an}, 32'hFE);
    check("first_seg", {25'h0, seg}, 32'h01);
    check("first_idx", {29'h0, digit_idx}, 32'h0);
    repeat (3) step();

    // Single tick: blank next cycle, digit 1 after the blank.
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("tick_an", {24'h0, an}, 32'hFF);
    check("tick_idx", {29'h0, digit_idx}, 32'h1);
    repeat (BLANK) step();
    check("d1_an", {24'h0, an}, 32'hFD);
    check("d1_seg", {25'h0, seg}, 32'h4F);
    repeat (2) step();

    // Tick held into BLANK is ignored.
    tick = 1'b1;
    step();
    step();
    step();
    tick = 1'b0;
    check("blank_tick_idx", {29'h0, digit_idx}, 32'h2);
    blen = 3;
    for (int k = 0; k < 20; k++) begin
      step();
      if (an == 8'hFF) blen++;
      else break;
    end
    check("blank_tick_len", blen, BLANK);
    check("blank_tick_idx2", {29'h0, digit_idx}, 32'h2);

    // Wrap: walk to digit 7, then eight more advances.
    for (int k = 0; k < 8 && m_idx != 7; k++) advance();
    check("at_seven", {29'h0, digit_idx}, 32'h7);
    advance();
    check("wrap_idx", {29'h0, digit_idx}, 32'h0);
    repeat (7) advance();
    check("wrap_back", {29'h0, digit_idx}, 32'h7);

    // Disabled digit 2 with its dp requested: anodes stay off, slot timing unchanged.
    digit_en = 8'hFB;
    dp       = 8'h04;
    step();
    for (int k = 0; k < 8 && m_idx != 1; k++) advance();
    tick_and_measure(1'b1, blen);
    check("dis_blank_len", blen, BLANK);
    check("dis_idx", {29'h0, digit_idx}, 32'h2);
    repeat (6) begin
      check("dis_an", {24'h0, an}, 32'hFF);
      step();
    end
    tick_and_measure(1'b0, blen);
    check("after_dis_len", blen, BLANK);
    digit_en = 8'hFF;
    dp       = 8'h00;

    // Randomised traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 15) == 0) data = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 31) == 0) dp = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 31) == 0) digit_en = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
      tick = ($urandom_range(0, 5) == 0);
      step();
    end
    tick = 1'b0;

    // Asynchronous reset mid-slot takes effect before any clock edge.
    repeat (3) step();
    rst = 1'b1;
    #1;
    check("async_an", {24'h0, an}, 32'hFF);
    check("async_seg", {25'h0, seg}, 32'h7F);
    check("async_dpn", {31'h0, dp_n}, 32'h1);
    check("async_idx", {29'h0, digit_idx}, 32'h0);
    model_reset();
    step();
    rst = 1'b0;

    // Leading-zero blanking pattern.
    data     = 32'h00000A05;
    digit_en = 8'hFF;
    dp       = 8'h00;
    repeat (BLANK) step();
    for (int d = 0; d < N; d++) begin
      exp_an = 8'hFF;
      exp_an[d] = 1'b0;
`ifdef SEVEN_SEG_MUX_LZB_EN
      if (d >= 3) exp_an = 8'hFF;
`endif
      check("lzb_an", {24'h0, an}, {24'h0, exp_an});
      check("lzb_seg", {25'h0, seg}, {25'h0, hex_tbl[data[4*d +: 4]]});
      step();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
